// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver with a small RX FIFO.
// Local-bus slave: DATA (0x0), STATUS (0x4), DIV (0x8), CTRL (0xC).
// Optional feature macro: UART_RX_IRQ_EN (adds o_uart_rx_irq and CTRL.irq_en).
module uart_rx_ip #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_uart_rx
`ifdef UART_RX_IRQ_EN
    ,
    output logic        o_uart_rx_irq
`endif
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Synchronizer
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        rx_s;

    // Receiver FSM
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dw_q, dw_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        armed_q, armed_d;
    logic        push_req_s;
    logic        frame_set_s;

    // FIFO and registers
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] div_q, div_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] ctrl_rd_s;

    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        push_s;
    logic        overrun_set_s;
    logic        wr_ok_s;
    logic        unused_ok_s;

    assign rx_s    = sync2_q;
    assign wready  = wen;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign wr_ok_s = wen & wstrb[0];
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_s   = ren && (raddr[3:0] == 4'h0) && !empty_s;
    assign push_s        = push_req_s && (!full_s || pop_s);
    assign overrun_set_s = push_req_s && full_s && !pop_s;

    assign unused_ok_s = ^{waddr[31:4], raddr[31:4], wdata[31:16], wstrb[3:1]};

    // Two-flop synchronizer for the asynchronous RX pin
    always_comb begin
        sync1_d = i_uart_rx;
        sync2_d = sync1_q;
    end

    // Receiver FSM next-state: start detect, mid-bit sampling, stop check
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dw_d        = dw_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        push_req_s  = 1'b0;
        frame_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    // Latch the divisor so DIV writes cannot disturb this frame
                    dw_d    = div_q;
                    cnt_d   = (div_q >> 1) - 16'd1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                        cnt_d   = dw_q - 16'd1;
                    end else begin
                        // Line came back high: treat as a glitch
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = dw_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rx_s) begin
                        push_req_s = 1'b1;
                    end else begin
                        frame_set_s = 1'b1;
                    end
                    // Require the line to be seen high before the next start
                    armed_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign o_uart_rx_irq = irq_q;
    assign ctrl_rd_s     = {31'd0, irq_en_q};

    // Interrupt enable register and registered interrupt request
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ok_s && (waddr[3:0] == 4'hC)) begin
            irq_en_d = wdata[0];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = irq_en_q & (~empty_s | overrun_q | frame_err_q);
    end

    // Interrupt flops
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign ctrl_rd_s = 32'd0;
`endif

    // FIFO pointers, sticky flags, divisor and bus read mux
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        div_d       = div_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rdata_d     = rdata_q;
        rvalid_d    = ren;

        if (push_s) begin
            mem_d[wr_ptr_q[PW-1:0]] = shift_q;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (wr_ok_s && (waddr[3:0] == 4'h8)) begin
            div_d = (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
        end else begin
            div_d = div_q;
        end

        // New events take priority over a same-cycle clear
        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (wr_ok_s && (waddr[3:0] == 4'h4) && wdata[2]) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (frame_set_s) begin
            frame_err_d = 1'b1;
        end else if (wr_ok_s && (waddr[3:0] == 4'h4) && wdata[3]) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end

        if (ren) begin
            case (raddr[3:0])
                4'h0:    rdata_d = empty_s ? 32'd0 : {24'd0, mem_q[rd_ptr_q[PW-1:0]]};
                4'h4:    rdata_d = {28'd0, frame_err_q, overrun_q, full_s, ~empty_s};
                4'h8:    rdata_d = {16'd0, div_q};
                4'hC:    rdata_d = ctrl_rd_s;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            dw_q        <= DIV_RST;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            armed_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            div_q       <= DIV_RST;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dw_q        <= dw_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            div_q       <= div_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ip.sv
// Self-checking bench for uart_rx_ip: directed steps plus randomized frames
// checked against a queue-based reference model of the receive FIFO/flags.
module tb_uart_rx_ip;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr, wdata, raddr;
    logic        wen, ren;
    logic [3:0]  wstrb;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rx;
`ifdef UART_RX_IRQ_EN
    logic        irq;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          div_cur;
    logic [7:0]  model_q [$];
    logic        m_ovr, m_fe;

    uart_rx_ip #(.CLK_DIV(104), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .waddr    (waddr),
        .wdata    (wdata),
        .wen      (wen),
        .wstrb    (wstrb),
        .wready   (wready),
        .raddr    (raddr),
        .ren      (ren),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .i_uart_rx(rx)
`ifdef UART_RX_IRQ_EN
        ,
        .o_uart_rx_irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr = {28'd0, a};
        wdata = d;
        wstrb = s;
        wen   = 1'b1;
        #1;
        check("wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wen   = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        raddr = {28'd0, a};
        ren   = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        d   = rdata;
        v   = rvalid;
        check({tag, "_vld"}, {31'd0, v}, 32'd1);
        check(tag, d, exp);
    endtask

    // 8N1 frame at div_cur clocks per bit, followed by a short idle gap
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (div_cur) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div_cur) @(negedge clk);
        end
        rx = stop;
        repeat (div_cur) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_fe = 1'b1;
        else if (model_q.size() == DEPTH) m_ovr = 1'b1;
        else model_q.push_back(b);
    endtask

    function automatic logic [31:0] model_status();
        return {28'd0, m_fe, m_ovr, model_q.size() == DEPTH, model_q.size() != 0};
    endfunction

    task automatic drain_check(input string tag);
        logic [7:0] e;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            rd_chk({tag, "_data"}, 4'h0, {24'd0, e});
        end
        rd_chk({tag, "_status"}, 4'h4, model_status());
    endtask

    initial begin
        logic [7:0] b;
        logic       st;
        int         nf;

        rst = 1'b1; rx = 1'b1; ren = 1'b0; wen = 1'b0;
        waddr = 32'd0; wdata = 32'd0; raddr = 32'd0; wstrb = 4'h0;
        m_ovr = 1'b0; m_fe = 1'b0; div_cur = 104;

        // Reset state
        idle(3);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
`ifdef UART_RX_IRQ_EN
        check("rst_irq", {31'd0, irq}, 32'd0);
`endif
        rst = 1'b0;
        idle(3);
        rd_chk("rst_status", 4'h4, 32'd0);
        rd_chk("rst_div", 4'h8, 32'd104);
        rd_chk("rst_ctrl", 4'hC, 32'd0);
        rd_chk("empty_data", 4'h0, 32'd0);
        rd_chk("empty_status", 4'h4, 32'd0);

        // DIV clamping, byte-enable gating, unmapped offsets, CTRL
        wr(4'h8, 32'd1, 4'h1);
        rd_chk("div_clamp1", 4'h8, 32'd2);
        wr(4'h8, 32'd0, 4'h1);
        rd_chk("div_clamp0", 4'h8, 32'd2);
        wr(4'h8, 32'd50, 4'h2);
        rd_chk("div_nostrb", 4'h8, 32'd2);
        wr(4'h8, 32'd16, 4'h1);
        div_cur = 16;
        rd_chk("div16", 4'h8, 32'd16);
        rd_chk("unmapped", 4'h1, 32'd0);
        wr(4'hC, 32'hFFFF_FFFF, 4'h1);
`ifdef UART_RX_IRQ_EN
        rd_chk("ctrl_rw", 4'hC, 32'd1);
        wr(4'hC, 32'd0, 4'h1);
`else
        rd_chk("ctrl_ro", 4'hC, 32'd0);
`endif

        // Single byte with exact push timing (push at cycle 154)
        fork
            send_frame(8'hA5, 1'b1);
            begin
                idle(154);
                rd_chk("a5_status_early", 4'h4, 32'h0);
                rd_chk("a5_status_at", 4'h4, 32'h1);
            end
        join
        model_frame(8'hA5, 1'b1);
        drain_check("a5");

        // Fill and overrun
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        rd_chk("fill_status", 4'h4, model_status());
        drain_check("fill");
        wr(4'h4, 32'h4, 4'h1);
        m_ovr = 1'b0;
        rd_chk("ovr_clear", 4'h4, model_status());

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        rd_chk("full_status", 4'h4, model_status());
        fork
            send_frame(8'h55, 1'b1);
            begin
                idle(154);
                b = model_q.pop_front();
                rd_chk("pp_pop", 4'h0, {24'd0, b});
            end
        join
        model_frame(8'h55, 1'b1);
        rd_chk("pp_status", 4'h4, model_status());
        drain_check("pp");

        // Frame error, then a short glitch
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        rd_chk("fe_status", 4'h4, model_status());
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        rd_chk("glitch_status", 4'h4, model_status());
        wr(4'h4, 32'h8, 4'h1);
        m_fe = 1'b0;
        rd_chk("fe_clear", 4'h4, model_status());

        // Randomized divisors, bytes and stop bits against the model
        for (int it = 0; it < 8; it++) begin
            div_cur = $urandom_range(2, 20);
            wr(4'h8, div_cur, 4'h1);
            nf = $urandom_range(1, 3);
            for (int k = 0; k < nf; k++) begin
                b  = 8'($urandom_range(0, 255));
                st = ($urandom_range(0, 7) != 0);
                send_frame(b, st);
                model_frame(b, st);
            end
            rd_chk("rnd_status", 4'h4, model_status());
            if ($urandom_range(0, 1) == 1) drain_check("rnd");
        end
        drain_check("rnd_end");
        wr(4'h4, 32'hC, 4'h1);
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        rd_chk("rnd_clear", 4'h4, model_status());

        // Reset mid-frame (during data bit 4)
        div_cur = 16;
        wr(4'h8, 32'd16, 4'h1);
        send_frame(8'h42, 1'b1);
        b  = 8'hE7;
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(16);
        end
        rx = b[4];
        idle(8);
        rst = 1'b1;
        idle(2);
        rx = 1'b1;
        idle(2);
        rst = 1'b0;
        model_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        div_cur = 104;
        idle(4);
        rd_chk("mrst_status", 4'h4, 32'd0);
        rd_chk("mrst_div", 4'h8, 32'd104);
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        drain_check("mrst");

`ifdef UART_RX_IRQ_EN
        // Interrupt behaviour
        div_cur = 16;
        wr(4'h8, 32'd16, 4'h1);
        send_frame(8'h11, 1'b1);
        idle(2);
        check("irq_off", {31'd0, irq}, 32'd0);
        wr(4'hC, 32'd1, 4'h1);
        check("irq_lag", {31'd0, irq}, 32'd0);
        idle(1);
        check("irq_on", {31'd0, irq}, 32'd1);
        rd_chk("irq_data", 4'h0, 32'h11);
        check("irq_hold", {31'd0, irq}, 32'd1);
        idle(1);
        check("irq_clr", {31'd0, irq}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
